lu_job_sched: RTL and testbench

- Job scheduler that sequences a stream of candidate coverage vectors through the shared LU hit-logic block, one per cycle.
- Accumulates hit and candidate counts, then returns one result per job on a valid/ready handshake.
- Sits between the candidate generator (distance/coverage stage) and the scoring/display logic.
- The LU instance is external: this block drives its covered/mode inputs and samples its hit output.

---
 rtl/lu_job_sched.sv | 120 ++++++++++++
 tb/tb_lu_job_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lu_job_sched.sv
// Job scheduler: streams candidate coverage vectors through the external LU
// hit block one per cycle, counts hits/candidates and returns one result per job.
`ifndef MODE_SZ
`define MODE_SZ 3
`endif
`ifndef COVERED_SZ
`define COVERED_SZ 3
`endif
`ifndef MODE1
`define MODE1 3'd1
`endif
`ifndef MODE2
`define MODE2 3'd2
`endif
`ifndef MODE3
`define MODE3 3'd3
`endif
`ifndef MODE4
`define MODE4 3'd4
`endif

module lu_job_sched #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [`MODE_SZ-1:0]    mode_i,
  output logic                   busy_o,
  input  logic                   cand_valid_i,
  output logic                   cand_ready_o,
  input  logic [`COVERED_SZ-1:0] cand_covered_i,
  input  logic                   cand_last_i,
  output logic [`COVERED_SZ-1:0] lu_covered_o,
  output logic [`MODE_SZ-1:0]    lu_mode_o,
  input  logic                   lu_hit_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [CNT_W-1:0]       res_count_o,
  output logic [CNT_W-1:0]       res_total_o,
  output logic                   res_ovf_o,
  output logic                   res_mode_err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic             issue;
  logic             handshake;
  logic             mode_ok;
  logic             job_start;
  logic [CNT_W-1:0] cnt_max;

  assign cnt_max   = '1;
  assign handshake = cand_valid_i & cand_ready_o;
  assign job_start = (state == IDLE) && start_i;
  assign mode_ok   = (mode_i == `MODE1) || (mode_i == `MODE2) ||
                     (mode_i == `MODE3) || (mode_i == `MODE4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy_o       = 1'b1;
    cand_ready_o = 1'b0;
    res_valid_o  = 1'b0;
    unique case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = RUN;
      end
      RUN: begin
        cand_ready_o = 1'b1;
        if (cand_valid_i && cand_last_i) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The LU sees lu_covered_o one cycle after the handshake, so its hit is
  // sampled on the edge after the issue flag was set, in whatever state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue          <= 1'b0;
      lu_covered_o   <= '0;
      lu_mode_o      <= '0;
      res_count_o    <= '0;
      res_total_o    <= '0;
      res_ovf_o      <= 1'b0;
      res_mode_err_o <= 1'b0;
    end else if (job_start) begin
      issue          <= 1'b0;
      lu_mode_o      <= mode_i;
      res_count_o    <= '0;
      res_total_o    <= '0;
      res_ovf_o      <= 1'b0;
      res_mode_err_o <= !mode_ok;
    end else begin
      issue <= handshake;
      if (handshake) begin
        lu_covered_o <= cand_covered_i;
        if (res_total_o == cnt_max) res_ovf_o   <= 1'b1;
        else                        res_total_o <= res_total_o + CNT_W'(1);
      end
      if (issue && lu_hit_i) begin
        if (res_count_o == cnt_max) res_ovf_o   <= 1'b1;
        else                        res_count_o <= res_count_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lu_job_sched.sv
// Directed bench for lu_job_sched: two instances (CNT_W=8 and CNT_W=2) share
// stimulus; a behavioural LU model and per-job result scoreboard check both.
`ifndef MODE_SZ
`define MODE_SZ 3
`endif
`ifndef COVERED_SZ
`define COVERED_SZ 3
`endif

module tb_lu_job_sched;

  typedef struct packed {
    logic [7:0] cnt;
    logic [7:0] tot;
    logic       ovf;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [`MODE_SZ-1:0] mode = '0;
  logic cand_valid = 1'b0;
  logic [`COVERED_SZ-1:0] cand_covered = '0;
  logic cand_last = 1'b0;
  logic res_ready = 1'b0;

  logic b8, cr8, rv8, ovf8, me8, hit8;
  logic [`COVERED_SZ-1:0] luc8;
  logic [`MODE_SZ-1:0] lum8;
  logic [7:0] cnt8, tot8;

  logic b2, cr2, rv2, ovf2, me2, hit2;
  logic [`COVERED_SZ-1:0] luc2;
  logic [`MODE_SZ-1:0] lum2;
  logic [1:0] cnt2, tot2;

  int tests = 0;
  int fails = 0;
  exp_t q8[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  // Behavioural LU: MODE1 hits on A, MODE2 on B, MODE3 on A xor B, MODE4 on C.
  function automatic logic lu_fn(input logic [2:0] m, input logic [2:0] c);
    case (m)
      3'd1:    return c[2];
      3'd2:    return c[1];
      3'd3:    return c[2] ^ c[1];
      3'd4:    return c[0];
      default: return 1'b0;
    endcase
  endfunction

  assign hit8 = lu_fn(lum8, luc8);
  assign hit2 = lu_fn(lum2, luc2);

  lu_job_sched #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .busy_o(b8),
    .cand_valid_i(cand_valid), .cand_ready_o(cr8), .cand_covered_i(cand_covered),
    .cand_last_i(cand_last), .lu_covered_o(luc8), .lu_mode_o(lum8), .lu_hit_i(hit8),
    .res_valid_o(rv8), .res_ready_i(res_ready), .res_count_o(cnt8), .res_total_o(tot8),
    .res_ovf_o(ovf8), .res_mode_err_o(me8)
  );

  lu_job_sched #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .busy_o(b2),
    .cand_valid_i(cand_valid), .cand_ready_o(cr2), .cand_covered_i(cand_covered),
    .cand_last_i(cand_last), .lu_covered_o(luc2), .lu_mode_o(lum2), .lu_hit_i(hit2),
    .res_valid_o(rv2), .res_ready_i(res_ready), .res_count_o(cnt2), .res_total_o(tot2),
    .res_ovf_o(ovf2), .res_mode_err_o(me2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sat_inc(inout int v, inout logic o, input int max);
    if (v == max) o = 1'b1;
    else v++;
  endtask

  task automatic run_job(input logic [2:0] m, input logic [2:0] cv[$],
                         input int gap[$], input int hold);
    exp_t e8, e2;
    int c8 = 0, t8 = 0, c2 = 0, t2 = 0;
    logic o8 = 1'b0, o2 = 1'b0, h;
    logic err;
    err = !(m inside {3'd1, 3'd2, 3'd3, 3'd4});
    start = 1'b1; mode = m;
    tick();
    start = 1'b0;
    chk("run_busy", b8, 1);
    chk("run_ready", cr8, 1);
    foreach (cv[i]) begin
      cand_valid = 1'b0; cand_last = 1'b0;
      repeat (gap[i]) tick();
      cand_valid = 1'b1; cand_covered = cv[i]; cand_last = (i == cv.size() - 1);
      tick();
      h = lu_fn(m, cv[i]);
      sat_inc(t8, o8, 255); sat_inc(t2, o2, 3);
      if (h) begin sat_inc(c8, o8, 255); sat_inc(c2, o2, 3); end
      chk("lu_covered", luc8, cv[i]);
    end
    cand_valid = 1'b0; cand_last = 1'b0;
    e8 = '{cnt: 8'(c8), tot: 8'(t8), ovf: o8, err: err};
    e2 = '{cnt: 8'(c2), tot: 8'(t2), ovf: o2, err: err};
    q8.push_back(e8); q2.push_back(e2);
    chk("drain_valid", rv8, 0);
    chk("drain_ready", cr8, 0);
    tick();
    chk("done_valid8", rv8, 1);
    chk("done_valid2", rv2, 1);
    chk("done_ready", cr8, 0);
    if (rv8 === 1'b1) begin
      e8 = q8.pop_front(); e2 = q2.pop_front();
    end else begin
      void'(q8.pop_front()); void'(q2.pop_front());
    end
    chk("count8", cnt8, e8.cnt); chk("total8", tot8, e8.tot);
    chk("ovf8", ovf8, e8.ovf);   chk("err8", me8, e8.err);
    chk("count2", cnt2, e2.cnt); chk("total2", tot2, e2.tot);
    chk("ovf2", ovf2, e2.ovf);   chk("err2", me2, e2.err);
    for (int k = 0; k < hold; k++) begin
      start = k[0];
      tick();
      start = 1'b0;
      chk("hold_valid", rv8, 1);
      chk("hold_count", cnt8, e8.cnt);
      chk("hold_total", tot8, e8.tot);
    end
    res_ready = 1'b1; start = (hold > 0);
    tick();
    res_ready = 1'b0; start = 1'b0;
    chk("idle_valid", rv8, 0);
    chk("idle_busy", b8, 0);
    chk("idle_count_hold", cnt8, e8.cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_busy", b8, 0);   chk("rst_ready", cr8, 0);
    chk("rst_valid", rv8, 0); chk("rst_luc", luc8, 0);
    chk("rst_lum", lum8, 0);  chk("rst_count", cnt8, 0);
    chk("rst_total", tot8, 0); chk("rst_ovf", ovf8, 0);
    #10 rst_n = 1'b1;
    tick();

    run_job(3'd1, '{3'b100, 3'b011, 3'b110, 3'b001}, '{0, 0, 0, 0}, 0);
    run_job(3'd4, '{3'b110, 3'b011, 3'b111, 3'b101, 3'b000}, '{0, 2, 1, 3, 0}, 0);
    run_job(3'd3, '{3'b100, 3'b010, 3'b110, 3'b000}, '{1, 0, 0, 0}, 5);
    run_job(3'd1, '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100}, '{0, 0, 0, 0, 0}, 0);
    run_job(3'd1, '{3'b000}, '{0}, 1);
    run_job(3'd7, '{3'b111, 3'b110}, '{0, 0}, 0);

    // Reset in the middle of a job
    start = 1'b1; mode = 3'd1;
    tick();
    start = 1'b0;
    cand_valid = 1'b1; cand_covered = 3'b100; tick();
    cand_covered = 3'b110; tick();
    cand_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", b8, 0);   chk("mid_rst_ready", cr8, 0);
    chk("mid_rst_valid", rv8, 0); chk("mid_rst_luc", luc8, 0);
    chk("mid_rst_lum", lum8, 0);  chk("mid_rst_count", cnt8, 0);
    chk("mid_rst_total", tot8, 0); chk("mid_rst_err", me8, 0);
    chk("mid_rst_count2", cnt2, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_valid", rv8, 0);
    end
    run_job(3'd2, '{3'b110, 3'b111}, '{0, 0}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
